// File: rtl/stopwatch_multi_digit.sv
// stopwatch_multi_digit: prescaled BCD stopwatch driving 7-segment digits; optional LAP_HOLD_EN adds lap display hold
module stopwatch_multi_digit #(
  parameter int NUM_DIGITS   = 3,
  parameter int TICK_DIV     = 50,
  parameter int DEBOUNCE_CYC = 16,
  parameter int ROLLOVER     = 1
) (
  input  logic                    sys_clk,
  input  logic                    reset_n,
  input  logic                    trigger_in,
  input  logic                    clear_in,
  input  logic                    lap_in,
  output logic [NUM_DIGITS*7-1:0] seg_out,
  output logic                    running,
  output logic                    overflow,
  output logic                    lap_active
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int LW = $clog2(DEBOUNCE_CYC + 1);
  localparam int DW = NUM_DIGITS * 4;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [LW-1:0] LOCK_LD = LW'(DEBOUNCE_CYC);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, FULL} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              meta_q, sync_q;
  logic                    trig_prev_q, lap_prev_q;
  logic [LW-1:0]           tlock_q, tlock_d, llock_q, llock_d;
  logic [PW-1:0]           pre_q, pre_d;
  logic [DW-1:0]           dig_q, dig_d, inc, disp;
  logic [NUM_DIGITS*7-1:0] seg_d;
  logic                    ovf_q, ovf_d;
  logic                    clr, trig, lap, tick, all9;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  assign clr      = sync_q[1];
  assign trig     = sync_q[0] & ~trig_prev_q & (tlock_q == '0);
  assign lap      = sync_q[2] & ~lap_prev_q & (llock_q == '0);
  assign tick     = (state_q == RUN) && (pre_q == PRE_MAX);
  assign overflow = ovf_q;

  // BCD increment with ripple carry; all9 flags full scale
  always_comb begin
    inc = dig_q;
    all9 = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (all9) inc[4*k+:4] = (dig_q[4*k+:4] == 4'd9) ? 4'd0 : dig_q[4*k+:4] + 4'd1;
      all9 = all9 && (dig_q[4*k+:4] == 4'd9);
    end
  end

  // Next state: clear wins, full-scale saturation wins over a same-cycle trigger
  always_comb begin
    state_d = state_q;
    if (clr) state_d = IDLE;
    else if (state_q == IDLE && trig) state_d = RUN;
    else if (state_q == RUN && tick && all9 && ROLLOVER == 0) state_d = FULL;
    else if (state_q == RUN && trig) state_d = PAUSE;
    else if (state_q == PAUSE && trig) state_d = RUN;
  end

  // Datapath next values; prescaler holds outside RUN so resume keeps the tick phase
  always_comb begin
    pre_d   = clr ? '0 : tick ? '0 : (state_q == RUN) ? pre_q + 1'b1 : pre_q;
    dig_d   = clr ? '0 : (tick && !(all9 && ROLLOVER == 0)) ? inc : dig_q;
    ovf_d   = !clr && (ovf_q || (tick && all9));
    tlock_d = clr ? '0 : trig ? LOCK_LD : (tlock_q != '0) ? tlock_q - 1'b1 : '0;
    llock_d = clr ? '0 : lap ? LOCK_LD : (llock_q != '0) ? llock_q - 1'b1 : '0;
  end

  // Segment decode of whatever is on display
  always_comb begin
    seg_d = '0;
    for (int k = 0; k < NUM_DIGITS; k++) seg_d[7*k+:7] = seg7(disp[4*k+:4]);
  end

  // Synchronisers, counters, state and registered outputs
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q      <= '0;
      sync_q      <= '0;
      trig_prev_q <= 1'b0;
      lap_prev_q  <= 1'b0;
      tlock_q     <= '0;
      llock_q     <= '0;
      state_q     <= IDLE;
      pre_q       <= '0;
      dig_q       <= '0;
      ovf_q       <= 1'b0;
      seg_out     <= {NUM_DIGITS{7'h3F}};
      running     <= 1'b0;
    end else begin
      meta_q      <= {lap_in, clear_in, trigger_in};
      sync_q      <= meta_q;
      trig_prev_q <= sync_q[0];
      lap_prev_q  <= sync_q[2];
      tlock_q     <= tlock_d;
      llock_q     <= llock_d;
      state_q     <= state_d;
      pre_q       <= pre_d;
      dig_q       <= dig_d;
      ovf_q       <= ovf_d;
      seg_out     <= seg_d;
      running     <= (state_q == RUN);
    end
  end

`ifdef LAP_HOLD_EN
  logic [DW-1:0] lap_q;
  logic          lap_act_q;

  // Alternate accepted lap edges capture and release a frozen copy of the count
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      lap_q     <= '0;
      lap_act_q <= 1'b0;
    end else if (clr) begin
      lap_act_q <= 1'b0;
    end else if (lap && (state_q == RUN || state_q == PAUSE)) begin
      lap_q     <= dig_q;
      lap_act_q <= ~lap_act_q;
    end
  end

  assign disp       = lap_act_q ? lap_q : dig_q;
  assign lap_active = lap_act_q;
`else
  logic unused_lap;

  assign unused_lap = lap;
  assign disp       = dig_q;
  assign lap_active = 1'b0;
`endif
endmodule
